// File: rtl/tlk2711_pkg.sv
// tlk2711_pkg: shared K-code words, K flag pairs, FSM states and lane geometry
// for the TLK2711 transmit path.
package tlk2711_pkg;
    localparam int LANES = 4;
    localparam logic [15:0] W_IDLE = 16'hBCC5;
    localparam logic [15:0] W_SOF  = 16'hFBFB;
    localparam logic [15:0] W_EOF  = 16'hFDFD;
    localparam logic [15:0] W_FILL = 16'hF7F7;
    localparam logic [1:0] K_IDLE = 2'b10;
    localparam logic [1:0] K_SOF  = 2'b11;
    localparam logic [1:0] K_EOF  = 2'b11;
    localparam logic [1:0] K_FILL = 2'b11;
    localparam logic [1:0] K_DATA = 2'b00;
    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_HDR0, S_HDR1, S_PAYLOAD, S_CSUM, S_EOF, S_GAP
    } state_t;
endpackage

// File: rtl/tlk2711_tx_gearbox.sv
// tlk2711_tx_gearbox: 64->16 lane buffer emitting one word per cycle, lane 0 first;
// a beat arriving into an empty buffer is forwarded in the same cycle.
module tlk2711_tx_gearbox
    import tlk2711_pkg::*;
#(
    parameter int BEAT_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  en,
    input  logic [BEAT_WIDTH-1:0] beats,
    input  logic [LANES*16-1:0]   s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic                  word_valid,
    output logic                  last,
    output logic [15:0]           word,
    output logic [15:0]           underrun_cnt
);
    logic [LANES*16-1:0] lanes_q;
    logic [1:0] lane;
    logic full, fill_q, take, fill;
    logic [BEAT_WIDTH-1:0] left;

    always_comb begin
        s_tready = en && left != '0 && (!full || lane == 2'(LANES - 1));
        take = s_tready && s_tvalid;
        word_valid = en && (full || take);
        word = full ? lanes_q[{lane, 4'b0000} +: 16] : s_tdata[15:0];
        last = en && full && lane == 2'(LANES - 1) && left == '0;
        fill = en && !word_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lanes_q <= '0;
            lane <= 2'd0;
            full <= 1'b0;
            left <= '0;
            fill_q <= 1'b0;
            underrun_cnt <= 16'd0;
        end else if (init) begin
            lane <= 2'd0;
            full <= 1'b0;
            left <= beats;
            fill_q <= 1'b0;
        end else if (en) begin
            if (take) begin
                lanes_q <= s_tdata;
                left <= left - BEAT_WIDTH'(1);
                full <= 1'b1;
                lane <= full ? 2'd0 : 2'd1;
            end else if (full) begin
                lane <= lane + 2'd1;
                full <= lane != 2'(LANES - 1);
            end
            fill_q <= fill;
            // one count per contiguous FILL run, taken on its first word
            if (fill && !fill_q && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
endmodule

// File: rtl/tlk2711_tx_framer.sv
// tlk2711_tx_framer: wraps DMA payload beats into SOF/header/payload/checksum/EOF
// frames on the TLK2711 transmit word, with K28.5 idles between frames.
module tlk2711_tx_framer
    import tlk2711_pkg::*;
#(
    parameter int STREAM_DATA_WIDTH = 64,
    parameter int DLEN_WIDTH = 16,
    parameter int IDLE_GAP = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_frame_start,
    input  logic [DLEN_WIDTH-1:0]        i_frame_len,
    input  logic [STREAM_DATA_WIDTH-1:0] i_s_tdata,
    input  logic                         i_s_tvalid,
    output logic                         o_s_tready,
    output logic [15:0]                  o_txd,
    output logic                         o_tkmsb,
    output logic                         o_tklsb,
    output logic                         o_busy,
    output logic                         o_frame_done,
    output logic                         o_start_err,
    output logic [15:0]                  o_underrun_cnt,
    output logic [15:0]                  o_frame_cnt
);
    localparam int BW = DLEN_WIDTH - 3;

    state_t state;
    logic [BW-1:0] beats, pend_beats, len_beats;
    logic [7:0] gap_cnt;
    logic [15:0] csum, gb_word;
    logic pend, take_pend, gb_valid, gb_last, unused_len;

    assign len_beats = i_frame_len[DLEN_WIDTH-1:3];
    assign unused_len = ^i_frame_len[2:0];
    assign take_pend = i_frame_start && state == S_GAP && gap_cnt != 8'd0 && !pend;

    tlk2711_tx_gearbox #(.BEAT_WIDTH(BW)) u_gearbox (
        .clk(clk),
        .rst(rst),
        .init(state == S_HDR1),
        .en(state == S_PAYLOAD),
        .beats(beats),
        .s_tdata(i_s_tdata),
        .s_tvalid(i_s_tvalid),
        .s_tready(o_s_tready),
        .word_valid(gb_valid),
        .last(gb_last),
        .word(gb_word),
        .underrun_cnt(o_underrun_cnt)
    );

    // state names the word being loaded into o_txd at the coming edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            o_txd <= W_IDLE;
            {o_tkmsb, o_tklsb} <= K_IDLE;
            o_busy <= 1'b0;
            o_frame_done <= 1'b0;
            o_start_err <= 1'b0;
            o_frame_cnt <= 16'd0;
            pend <= 1'b0;
            pend_beats <= '0;
            beats <= '0;
            gap_cnt <= 8'd0;
            csum <= 16'd0;
        end else begin
            o_frame_done <= 1'b0;
            o_start_err <= i_frame_start && !take_pend && state != S_IDLE;
            {o_tkmsb, o_tklsb} <= K_DATA;
            if (take_pend) begin
                pend <= 1'b1;
                pend_beats <= len_beats;
            end
            case (state)
                S_IDLE: begin
                    o_txd <= i_frame_start ? W_SOF : W_IDLE;
                    {o_tkmsb, o_tklsb} <= i_frame_start ? K_SOF : K_IDLE;
                    o_busy <= i_frame_start;
                    beats <= len_beats;
                    state <= i_frame_start ? S_HDR0 : S_IDLE;
                end
                S_SOF: begin
                    o_txd <= W_SOF;
                    {o_tkmsb, o_tklsb} <= K_SOF;
                    beats <= pend_beats;
                    pend <= 1'b0;
                    state <= S_HDR0;
                end
                S_HDR0: begin
                    o_txd <= o_frame_cnt;
                    csum <= 16'd0;
                    state <= S_HDR1;
                end
                S_HDR1: begin
                    o_txd <= 16'({beats, 2'b00});
                    state <= beats != '0 ? S_PAYLOAD : S_CSUM;
                end
                S_PAYLOAD: begin
                    o_txd <= gb_valid ? gb_word : W_FILL;
                    {o_tkmsb, o_tklsb} <= gb_valid ? K_DATA : K_FILL;
                    if (gb_valid) csum <= csum + gb_word;
                    if (gb_last) state <= S_CSUM;
                end
                S_CSUM: begin
                    o_txd <= csum;
                    state <= S_EOF;
                end
                S_EOF: begin
                    o_txd <= W_EOF;
                    {o_tkmsb, o_tklsb} <= K_EOF;
                    o_frame_done <= 1'b1;
                    gap_cnt <= 8'd0;
                    state <= S_GAP;
                end
                S_GAP: begin
                    o_txd <= W_IDLE;
                    {o_tkmsb, o_tklsb} <= K_IDLE;
                    gap_cnt <= gap_cnt + 8'd1;
                    if (gap_cnt == 8'd0) o_frame_cnt <= o_frame_cnt + 16'd1;
                    if (gap_cnt == 8'(IDLE_GAP - 1)) state <= (pend || take_pend) ? S_SOF : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tlk2711_tx_framer.sv
// tb_tlk2711_tx_framer: directed frames checked word-by-word (txd, K, busy, done, err)
// against hand-built expected sequences.
module tb_tlk2711_tx_framer;
    typedef logic [18:0] ent_t;
    localparam ent_t SOF_E = {1'b1, 2'b11, 16'hFBFB};
    localparam ent_t EOF_E = {1'b1, 2'b11, 16'hFDFD};
    localparam ent_t GAP_E = {1'b1, 2'b10, 16'hBCC5};
    localparam ent_t IDL_E = {1'b0, 2'b10, 16'hBCC5};
    localparam ent_t FIL_E = {1'b1, 2'b11, 16'hF7F7};

    logic clk = 0, rst = 1, frame_start = 0;
    logic [15:0] frame_len = 0;
    logic [63:0] s_tdata = 0;
    logic s_tvalid = 0;
    logic s_tready, tkmsb, tklsb, busy, frame_done, start_err;
    logic [15:0] txd, underrun_cnt, frame_cnt;
    int checks = 0, failures = 0, nacc = 0, stall = 0, stall_at = -1, stall_n = 0;
    logic [63:0] bq[$];
    ent_t q[$];

    always #5 clk = ~clk;

    tlk2711_tx_framer dut (
        .clk(clk), .rst(rst), .i_frame_start(frame_start), .i_frame_len(frame_len),
        .i_s_tdata(s_tdata), .i_s_tvalid(s_tvalid), .o_s_tready(s_tready),
        .o_txd(txd), .o_tkmsb(tkmsb), .o_tklsb(tklsb), .o_busy(busy),
        .o_frame_done(frame_done), .o_start_err(start_err),
        .o_underrun_cnt(underrun_cnt), .o_frame_cnt(frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic ent_t d(input logic [15:0] w);
        return {1'b1, 2'b00, w};
    endfunction

    task automatic run(input string nm, input ent_t seq[$], input int inj,
                       input logic [15:0] inj_len, input logic inj_err);
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            frame_start = (i == inj);
            if (i == inj) frame_len = inj_len;
            check($sformatf("%s[%0d].txd", nm, i), txd, seq[i][15:0]);
            check($sformatf("%s[%0d].k", nm, i), {tkmsb, tklsb}, seq[i][17:16]);
            check($sformatf("%s[%0d].busy", nm, i), busy, seq[i][18]);
            check($sformatf("%s[%0d].done", nm, i), frame_done, seq[i] == EOF_E);
            check($sformatf("%s[%0d].err", nm, i), start_err, inj_err && i == inj + 1);
        end
        frame_start = 0;
    endtask

    initial begin
        logic hs;
        forever begin
            @(negedge clk);
            hs = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            if (hs) begin
                void'(bq.pop_front());
                nacc++;
                if (nacc == stall_at) stall = stall_n;
            end else if (stall > 0) stall--;
            s_tvalid = bq.size() > 0 && stall == 0;
            s_tdata = bq.size() > 0 ? bq[0] : 64'd0;
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst.txd", txd, 16'hBCC5);
        check("rst.k", {tkmsb, tklsb}, 2'b10);
        check("rst.tready", s_tready, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.done", frame_done, 1'b0);
        check("rst.err", start_err, 1'b0);
        check("rst.underrun", underrun_cnt, 16'd0);
        check("rst.fcnt", frame_cnt, 16'd0);
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle.txd", txd, 16'hBCC5);
            check("idle.k", {tkmsb, tklsb}, 2'b10);
            check("idle.busy", busy, 1'b0);
            check("idle.tready", s_tready, 1'b0);
        end
        // len=16, beats presented before the request must wait
        bq.push_back(64'h0003_0002_0001_0000);
        bq.push_back(64'h0007_0006_0005_0004);
        repeat (3) begin
            @(negedge clk);
            check("early.tready", s_tready, 1'b0);
        end
        check("early.nacc", nacc, 0);
        frame_len = 16;
        frame_start = 1;
        q = '{SOF_E, d(16'h0), d(16'h8), d(16'h0), d(16'h1), d(16'h2), d(16'h3), d(16'h4),
              d(16'h5), d(16'h6), d(16'h7), d(16'h1C), EOF_E, GAP_E, GAP_E, GAP_E, GAP_E, IDL_E};
        run("f16", q, -1, 16'd0, 1'b0);
        check("f16.fcnt", frame_cnt, 16'd1);
        check("f16.nacc", nacc, 2);
        // tvalid low 6 cycles after beat 0: lane 3 consumes 3 of them, 3 FILL words remain
        stall_at = nacc + 1;
        stall_n = 6;
        bq.push_back(64'h0003_0002_0001_0000);
        bq.push_back(64'h0007_0006_0005_0004);
        frame_start = 1;
        q = '{SOF_E, d(16'h1), d(16'h8), d(16'h0), d(16'h1), d(16'h2), d(16'h3), FIL_E, FIL_E,
              FIL_E, d(16'h4), d(16'h5), d(16'h6), d(16'h7), d(16'h1C), EOF_E,
              GAP_E, GAP_E, GAP_E, GAP_E, IDL_E};
        run("stall", q, -1, 16'd0, 1'b0);
        check("stall.underrun", underrun_cnt, 16'd1);
        check("stall.fcnt", frame_cnt, 16'd2);
        // len=7 truncates to zero beats; a waiting beat must not be taken
        bq.push_back(64'h0040_0030_0020_0010);
        frame_len = 7;
        frame_start = 1;
        q = '{SOF_E, d(16'h2), d(16'h0), d(16'h0), EOF_E, GAP_E, GAP_E, GAP_E, GAP_E, IDL_E};
        run("len0", q, -1, 16'd0, 1'b0);
        check("len0.nacc", nacc, 4);
        check("len0.fcnt", frame_cnt, 16'd3);
        // start while HDR1 is on the wire is rejected
        frame_len = 8;
        frame_start = 1;
        q = '{SOF_E, d(16'h3), d(16'h4), d(16'h10), d(16'h20), d(16'h30), d(16'h40), d(16'hA0),
              EOF_E, GAP_E, GAP_E, GAP_E, GAP_E, IDL_E};
        run("herr", q, 2, 16'd16, 1'b1);
        check("herr.fcnt", frame_cnt, 16'd4);
        check("herr.nacc", nacc, 5);
        // start during the gap is held and follows the 4th idle word directly
        bq.push_back(64'h0004_0003_0002_0001);
        frame_len = 0;
        frame_start = 1;
        q = '{SOF_E, d(16'h4), d(16'h0), d(16'h0), EOF_E, GAP_E, GAP_E, GAP_E, GAP_E,
              SOF_E, d(16'h5), d(16'h4), d(16'h1), d(16'h2), d(16'h3), d(16'h4), d(16'hA),
              EOF_E, GAP_E, GAP_E, GAP_E, GAP_E, IDL_E};
        run("gap", q, 6, 16'd8, 1'b0);
        check("gap.fcnt", frame_cnt, 16'd6);
        // reset in the middle of the first beat abandons the frame
        bq.push_back(64'h0003_0002_0001_0000);
        bq.push_back(64'h0007_0006_0005_0004);
        frame_len = 16;
        frame_start = 1;
        q = '{SOF_E, d(16'h6), d(16'h8), d(16'h0), d(16'h1)};
        run("pre", q, -1, 16'd0, 1'b0);
        rst = 1;
        @(negedge clk);
        check("mrst.txd", txd, 16'hBCC5);
        check("mrst.k", {tkmsb, tklsb}, 2'b10);
        check("mrst.busy", busy, 1'b0);
        check("mrst.done", frame_done, 1'b0);
        check("mrst.tready", s_tready, 1'b0);
        check("mrst.fcnt", frame_cnt, 16'd0);
        check("mrst.underrun", underrun_cnt, 16'd0);
        rst = 0;
        bq.delete();
        @(negedge clk);
        check("post.txd", txd, 16'hBCC5);
        bq.push_back(64'h0008_0007_0006_0005);
        frame_len = 8;
        frame_start = 1;
        q = '{SOF_E, d(16'h0), d(16'h4), d(16'h5), d(16'h6), d(16'h7), d(16'h8), d(16'h1A),
              EOF_E, GAP_E, GAP_E, GAP_E, GAP_E, IDL_E};
        run("post", q, -1, 16'd0, 1'b0);
        check("post.fcnt", frame_cnt, 16'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
